// File: rtl/cmos_pkg.sv
// Shared definitions for the dual-OV5640 vsync alignment block.
package cmos_pkg;
    typedef enum logic [1:0] {IDLE, WAIT0, WAIT1, HOLD} state_t;

    localparam int MAX_SKEW_DEF    = 4000;
    localparam int LOCK_FRAMES_DEF = 4;
    localparam int NUM_CAM         = 2;
endpackage

// File: rtl/vsync_sync_edge.sv
// 2-flop synchronizer plus registered rising-edge detector for one camera vsync.
module vsync_sync_edge
    import cmos_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic vsync,
    output logic lvl,
    output logic rise
);
    logic [1:0] sync;
    logic [1:0] vld_pipe;
    logic       prev;
    logic       armed;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync     <= '0;
            vld_pipe <= '0;
            prev     <= 1'b0;
            armed    <= 1'b0;
            rise     <= 1'b0;
        end else begin
            sync     <= {sync[0], vsync};
            vld_pipe <= {vld_pipe[0], 1'b1};
            prev     <= sync[1];
            // only arm once a real low has been seen, so a vsync held high across reset is not an edge
            armed    <= armed | (vld_pipe[1] & ~sync[1]);
            rise     <= sync[1] & ~prev & armed;
        end
    end

    assign lvl = sync[1];
endmodule

// File: rtl/cmos_vsync_align.sv
// Aligns two camera vsyncs into one merged vsync, measuring inter-camera skew and tracking lock.
module cmos_vsync_align
    import cmos_pkg::*;
#(
    parameter int SKEW_W      = 16,
    parameter int MAX_SKEW    = MAX_SKEW_DEF,
    parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmos0_vsync,
    input  logic              cmos1_vsync,
    output logic              pixel_vsync,
    output logic [SKEW_W-1:0] skew,
    output logic              lead,
    output logic              locked,
    output logic              skew_err
);
    localparam int LW = $clog2(LOCK_FRAMES + 1);

    logic [NUM_CAM-1:0] vs_in, lvl, rise;
    assign vs_in = {cmos1_vsync, cmos0_vsync};

    for (genvar i = 0; i < NUM_CAM; i++) begin : g_cam
        vsync_sync_edge u_se (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .vsync (vs_in[i]),
            .lvl   (lvl[i]),
            .rise  (rise[i])
        );
    end

    state_t            state, nstate;
    logic [SKEW_W-1:0] cnt, skew_nxt;
    logic [LW-1:0]     lock_cnt;
    logic              lead_nxt, cnt_clr, cnt_inc, enter, err;

    always_comb begin
        nstate   = state;
        skew_nxt = skew;
        lead_nxt = lead;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        enter    = 1'b0;
        err      = 1'b0;
        case (state)
            IDLE: begin
                if (rise[0] && rise[1]) begin
                    skew_nxt = '0;
                    lead_nxt = 1'b0;
                    enter    = 1'b1;
                    nstate   = HOLD;
                end else if (rise[0]) begin
                    cnt_clr  = 1'b1;
                    lead_nxt = 1'b0;
                    nstate   = WAIT1;
                end else if (rise[1]) begin
                    cnt_clr  = 1'b1;
                    lead_nxt = 1'b1;
                    nstate   = WAIT0;
                end
            end
            WAIT0, WAIT1: begin
                // the awaited edge wins over a repeat or a timeout in the same cycle
                if (rise[(state == WAIT1) ? 1 : 0]) begin
                    skew_nxt = cnt + SKEW_W'(1);
                    enter    = 1'b1;
                    nstate   = HOLD;
                end else if (rise[(state == WAIT1) ? 0 : 1]) begin
                    err     = 1'b1;
                    cnt_clr = 1'b1;
                end else if (cnt == SKEW_W'(MAX_SKEW - 1)) begin
                    err    = 1'b1;
                    nstate = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            HOLD: begin
                if (lvl == '0) nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            skew     <= '0;
            lead     <= 1'b0;
            lock_cnt <= '0;
        end else begin
            state <= nstate;
            skew  <= skew_nxt;
            lead  <= lead_nxt;
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + SKEW_W'(1);
            if (err)                                        lock_cnt <= '0;
            else if (enter && lock_cnt != LW'(LOCK_FRAMES)) lock_cnt <= lock_cnt + LW'(1);
        end
    end

    assign pixel_vsync = enter | ((state == HOLD) & (|lvl));
    assign locked      = (lock_cnt == LW'(LOCK_FRAMES));
    assign skew_err    = err;
endmodule

// File: tb/tb_cmos_vsync_align.sv
// Randomized scoreboard bench for cmos_vsync_align with a frame-level reference model.
module tb_cmos_vsync_align;
    localparam int SW = 16;
    localparam int MS = 300;
    localparam int LF = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          cmos0_vsync = 1'b0;
    logic          cmos1_vsync = 1'b0;
    logic          pixel_vsync, lead, locked, skew_err;
    logic [SW-1:0] skew;

    cmos_vsync_align #(.SKEW_W(SW), .MAX_SKEW(MS), .LOCK_FRAMES(LF)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmos0_vsync (cmos0_vsync),
        .cmos1_vsync (cmos1_vsync),
        .pixel_vsync (pixel_vsync),
        .skew        (skew),
        .lead        (lead),
        .locked      (locked),
        .skew_err    (skew_err)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int cyc;
        int skew;
        int lead;
        int locked;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   mlock = 0;
    bit   pend = 0, epend = 0, pv_d = 0;
    exp_t pe;

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    task automatic chk(string name, int act, int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected result of a successful frame: skew is the distance between the two rises.
    task automatic push_aligned(int base, int t0, int t1);
        exp_t e;
        int d = t1 - t0;
        e.cyc  = base + ((t0 > t1) ? t0 : t1) + 3;
        e.skew = (d < 0) ? -d : d;
        e.lead = (d < 0) ? 1 : 0;
        mlock  = (mlock < LF) ? mlock + 1 : LF;
        e.locked = (mlock == LF) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    // t<0 means that camera stays low for the whole frame.
    task automatic frame(int t0, int h0, int t1, int h1);
        int base, len, ts;
        @(posedge clk_i); #1;
        base = cyc;
        if (t0 >= 0 && t1 >= 0) begin
            push_aligned(base, t0, t1);
            len = ((t0 + h0 > t1 + h1) ? t0 + h0 : t1 + h1) + 12;
        end else begin
            ts = (t0 >= 0) ? t0 : t1;
            err_q.push_back(base + ts + 3 + MS);
            mlock = 0;
            len = ts + MS + 12 + ((t0 >= 0) ? h0 : h1);
        end
        for (int t = 0; t < len; t++) begin
            cmos0_vsync = (t0 >= 0) && (t >= t0) && (t < t0 + h0);
            cmos1_vsync = (t1 >= 0) && (t >= t1) && (t < t1 + h1);
            @(posedge clk_i); #1;
        end
        cmos0_vsync = 1'b0;
        cmos1_vsync = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT enters HOLD or flags an error.
    initial forever begin
        @(negedge clk_i);
        if (pend) begin
            chk("skew", int'(skew), pe.skew);
            chk("lead", int'(lead), pe.lead);
            chk("locked", int'(locked), pe.locked);
            pend = 0;
        end
        if (epend) begin
            chk("locked_after_err", int'(locked), 0);
            epend = 0;
        end
        if (!rst_i && pixel_vsync && !pv_d) begin
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_hold: pixel_vsync rose at cycle %0d, none expected", cyc);
            end else begin
                pe = exp_q.pop_front();
                chk("hold_cycle", cyc, pe.cyc);
                pend = 1;
            end
        end
        if (!rst_i && skew_err) begin
            if (err_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_err: skew_err at cycle %0d, none expected", cyc);
            end else begin
                chk("err_cycle", cyc, err_q.pop_front());
                epend = 1;
            end
        end
        pv_d = pixel_vsync;
    end

    initial begin
        int d, h0, h1, base;
        bit bad;
        exp_t e;
        cmos0_vsync = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_pixel_vsync", int'(pixel_vsync), 0);
        chk("rst_skew", int'(skew), 0);
        chk("rst_lead", int'(lead), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_skew_err", int'(skew_err), 0);
        cmos0_vsync = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        repeat (5) @(posedge clk_i);

        frame(0, 8, 0, 8);
        frame(0, 110, 100, 10);
        frame(0, 10, -1, 0);
        chk("locked_after_timeout", int'(locked), 0);

        for (int i = 0; i < 4; i++) frame(0, 30, 20, 10);
        chk("locked_after_4", int'(locked), 1);
        frame(0, 10, -1, 0);

        // cam0 rises twice before cam1: the repeat errors and restarts the measurement
        @(posedge clk_i); #1;
        base = cyc;
        err_q.push_back(base + 23);
        mlock = 0;
        push_aligned(base + 20, 0, 10);
        for (int t = 0; t < 52; t++) begin
            cmos0_vsync = (t < 5) || (t >= 20 && t < 40);
            cmos1_vsync = (t >= 30 && t < 40);
            @(posedge clk_i); #1;
        end
        cmos0_vsync = 1'b0;
        cmos1_vsync = 1'b0;

        frame(0, MS + 5, MS, 6);
        frame(MS, 6, 0, MS + 5);

        for (int i = 0; i < 16; i++) begin
            h0 = int'($urandom_range(4, 30));
            h1 = int'($urandom_range(4, 30));
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 1) frame(0, h0, -1, 0);
                else                           frame(-1, 0, 0, h1);
            end else begin
                d = int'($urandom_range(0, 2 * MS)) - MS;
                if (d >= 0) frame(0, h0, d, h1);
                else        frame(-d, h0, 0, h1);
            end
        end

        // reset in the middle of HOLD with both vsyncs high
        @(posedge clk_i); #1;
        base = cyc;
        push_aligned(base, 0, 0);
        cmos0_vsync = 1'b1;
        cmos1_vsync = 1'b1;
        repeat (6) begin @(posedge clk_i); #1; end
        chk("hold_pixel_vsync", int'(pixel_vsync), 1);
        rst_i = 1'b1;
        #1;
        chk("rst_mid_frame_pixel", int'(pixel_vsync), 0);
        mlock = 0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        bad = 0;
        repeat (20) begin
            @(posedge clk_i); #1;
            if (pixel_vsync) bad = 1;
        end
        chk("no_hold_after_rst", int'(bad), 0);
        cmos0_vsync = 1'b0;
        cmos1_vsync = 1'b0;
        repeat (10) @(posedge clk_i);
        frame(0, 8, 5, 8);

        for (int i = 0; i < 2000 && (exp_q.size() != 0 || err_q.size() != 0 || pend || epend); i++)
            @(negedge clk_i);
        chk("drain_hold_q", exp_q.size(), 0);
        chk("drain_err_q", err_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cmos_vsync_align.md
CMOS_VSYNC_ALIGN -- requirements
Module: cmos_vsync_align

Interface
REQ-001 SHALL have parameter SKEW_W, default 16, meaning the width of the skew counter and skew output.
REQ-002 SHALL have parameter MAX_SKEW, default 4000, meaning the largest allowed inter-camera vsync offset in clk_i cycles.
REQ-003 SHALL have parameter LOCK_FRAMES, default 4, meaning the number of consecutive aligned frames required to assert locked.
REQ-004 SHALL use one clock, clk_i, and one reset, rst_i; rst_i is asynchronous and active-high.
REQ-005 SHALL have port clk_i, input, 1 bit: the single processing clock (counter_clk domain).
REQ-006 SHALL have port rst_i, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port cmos0_vsync, input, 1 bit: OV5640 #0 vsync, active-high, asynchronous to clk_i.
REQ-008 SHALL have port cmos1_vsync, input, 1 bit: OV5640 #1 vsync, active-high, asynchronous to clk_i.
REQ-009 SHALL have port pixel_vsync, output, 1 bit: merged vsync driven to the dual-stream combiner.
REQ-010 SHALL have port skew, output, SKEW_W bits: last measured offset between the two vsync edges, in clk_i cycles.
REQ-011 SHALL have port lead, output, 1 bit: 0 when cam0's edge came first or both edges coincided, 1 when cam1's edge came first.
REQ-012 SHALL have port locked, output, 1 bit: asserted after LOCK_FRAMES consecutive aligned frames.
REQ-013 SHALL have port skew_err, output, 1 bit: one-cycle pulse on any alignment failure.

Function
REQ-014 SHALL pass each vsync through a 2-flop synchronizer, then a rising-edge detector, producing rise0/rise1 pulses 3 cycles after the input edge.
REQ-015 SHALL implement an FSM with states IDLE, WAIT0, WAIT1, HOLD.
REQ-016 In IDLE, rise0&rise1 in the same cycle SHALL load skew=0, lead=0, and go to HOLD.
REQ-017 In IDLE, rise0 alone SHALL clear cnt, set lead=0, and go to WAIT1; rise1 alone SHALL clear cnt, set lead=1, and go to WAIT0.
REQ-018 In WAIT0/WAIT1, cnt SHALL increment every cycle.
REQ-019 In WAIT0/WAIT1, the awaited edge SHALL load skew=cnt+1 (pulse-to-pulse distance) and go to HOLD.
REQ-020 In WAIT1 a repeated rise0, or in WAIT0 a repeated rise1, SHALL pulse skew_err, clear cnt, and stay in the same state.
REQ-021 In WAIT0/WAIT1, when cnt reaches MAX_SKEW without the awaited edge, the block SHALL pulse skew_err and return to IDLE, with skew unchanged.
REQ-022 pixel_vsync SHALL rise on the cycle HOLD is entered and stay high while either synchronized vsync is high.
REQ-023 HOLD SHALL return to IDLE when both synchronized vsyncs are low; pixel_vsync SHALL fall in that same cycle.
REQ-024 Edges arriving in HOLD SHALL be ignored.
REQ-025 The lock counter SHALL increment on each HOLD entry and saturate at LOCK_FRAMES.
REQ-026 locked SHALL be 1 when the lock counter equals LOCK_FRAMES.
REQ-027 Any skew_err pulse SHALL clear the lock counter and locked in the next cycle.
REQ-028 cnt SHALL never wrap; MAX_SKEW SHALL be at most 2^SKEW_W-2.

Reset
REQ-029 rst_i SHALL asynchronously force the FSM to IDLE and clear synchronizers, cnt, and the lock counter.
REQ-030 During reset, outputs SHALL be pixel_vsync=0, skew=0, lead=0, locked=0, skew_err=0.
REQ-031 Reset asserted mid-frame SHALL drop pixel_vsync immediately.
REQ-032 After release, a vsync already high SHALL NOT generate a rise pulse until it goes low and rises again.

Structure
REQ-033 The FSM state enumeration and the MAX_SKEW/LOCK_FRAMES defaults SHALL reside in shared package cmos_pkg.
REQ-034 One sub-module, vsync_sync_edge (2-flop synchronizer plus edge detector), SHALL be instantiated once per camera.

Verification
REQ-035 Both vsyncs rising in the same cycle -> pixel_vsync high 3 cycles later, skew=0, lead=0.
REQ-036 cmos1_vsync rising 100 cycles after cmos0_vsync -> skew=100, lead=0, pixel_vsync rises with the cam1 pulse.
REQ-037 Only cmos0_vsync toggling -> skew_err pulse exactly MAX_SKEW cycles after rise0, FSM returns to IDLE, locked=0.
REQ-038 Four aligned frames (skew=20) -> locked=1 after the 4th HOLD entry; a fifth frame that times out -> locked=0 in the cycle after skew_err.
REQ-039 rst_i asserted during HOLD with both vsyncs high -> pixel_vsync=0 immediately; no HOLD entry until fresh rising edges occur after release.
